// File: rtl/mor1kx_tlb_reload_responder_pkg.sv
// rtl/mor1kx_tlb_reload_responder_pkg.sv - shared encodings for the TLB reload responder
package mor1kx_tlb_reload_responder_pkg;

    typedef enum logic [1:0] {
        RLD_IDLE = 2'd0,
        RLD_BUS  = 2'd1,
        RLD_RESP = 2'd2
    } rld_state_t;

    localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
    localparam logic [1:0] WB_BTE_LINEAR  = 2'b00;

    // One-hot grant encodings: bit 0 is the IMMU, bit 1 is the DMMU.
    localparam logic [1:0] GNT_IMMU = 2'b01;
    localparam logic [1:0] GNT_DMMU = 2'b10;

endpackage

// File: rtl/mor1kx_tlb_reload_arb.sv
// rtl/mor1kx_tlb_reload_arb.sv - 2-way sticky round-robin grant for reload requests
module mor1kx_tlb_reload_arb
    import mor1kx_tlb_reload_responder_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       idle_i,
    output logic [1:0] grant_o
);

    logic [1:0] owner_q;
    logic [1:0] last_q;
    logic       hold_q;
    logic [1:0] grant;

    // Ownership persists only while the owner's req stays continuously high,
    // so a multi-level walk is never interleaved but a reissue re-arbitrates.
    always_comb begin
        grant = owner_q;
        if (hold_q && |(req_i & owner_q)) begin
            grant = owner_q;
        end else if (req_i == 2'b11) begin
            grant = (last_q == GNT_DMMU) ? GNT_IMMU : GNT_DMMU;
        end else if (req_i[0]) begin
            grant = GNT_IMMU;
        end else if (req_i[1]) begin
            grant = GNT_DMMU;
        end
    end

    assign grant_o = grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q <= GNT_IMMU;
            last_q  <= GNT_DMMU;
            hold_q  <= 1'b0;
        end else if (idle_i && |(req_i & grant)) begin
            owner_q <= grant;
            last_q  <= grant;
            hold_q  <= 1'b1;
        end else if (!(|(req_i & owner_q))) begin
            hold_q  <= 1'b0;
        end
    end

endmodule

// File: rtl/mor1kx_tlb_reload_responder.sv
// rtl/mor1kx_tlb_reload_responder.sv - arbitrated single-word Wishbone reads for IMMU/DMMU TLB reload
module mor1kx_tlb_reload_responder
    import mor1kx_tlb_reload_responder_pkg::*;
#(
    parameter int OPTION_OPERAND_WIDTH  = 32,
    parameter int OPTION_RELOAD_TIMEOUT = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            immu_req_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] immu_addr_i,
    output logic                            immu_ack_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] immu_data_o,
    input  logic                            dmmu_req_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] dmmu_addr_i,
    output logic                            dmmu_ack_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] dmmu_data_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] wbm_adr_o,
    output logic                            wbm_cyc_o,
    output logic                            wbm_stb_o,
    output logic                            wbm_we_o,
    output logic [3:0]                      wbm_sel_o,
    output logic [2:0]                      wbm_cti_o,
    output logic [1:0]                      wbm_bte_o,
    input  logic [OPTION_OPERAND_WIDTH-1:0] wbm_dat_i,
    input  logic                            wbm_ack_i,
    input  logic                            wbm_err_i,
    output logic                            busy_o
);

    localparam int W = OPTION_OPERAND_WIDTH;

    rld_state_t  state_q;
    logic [1:0]  gnt_q;
    logic [W-1:0] adr_q;
    logic        cyc_q;
    logic        abort_q;
    logic        immu_ack_q;
    logic        dmmu_ack_q;
    logic [W-1:0] immu_data_q;
    logic [W-1:0] dmmu_data_q;

    logic [1:0]  grant;
    logic        timeout;
    logic        bus_fail;
    logic        bus_done;
    logic        gnt_req;
    logic [W-1:0] bus_word;

    mor1kx_tlb_reload_arb u_arb (
        .clk     (clk),
        .rst     (rst),
        .req_i   ({dmmu_req_i, immu_req_i}),
        .idle_i  (state_q == RLD_IDLE),
        .grant_o (grant)
    );

    generate
        if (OPTION_RELOAD_TIMEOUT > 0) begin : g_timeout
            localparam int CW = $clog2(OPTION_RELOAD_TIMEOUT + 1);
            logic [CW-1:0] cnt_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_q <= '0;
                end else if (state_q != RLD_BUS) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end

            assign timeout = (state_q == RLD_BUS) &&
                             (cnt_q == CW'(OPTION_RELOAD_TIMEOUT - 1));
        end else begin : g_no_timeout
            assign timeout = 1'b0;
        end
    endgenerate

    // A failed read returns zero so the MMU falls into its own pagefault path.
    assign bus_fail = wbm_err_i | timeout;
    assign bus_done = wbm_ack_i | bus_fail;
    assign bus_word = bus_fail ? '0 : wbm_dat_i;
    assign gnt_req  = |(gnt_q & {dmmu_req_i, immu_req_i});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RLD_IDLE;
            gnt_q       <= GNT_IMMU;
            adr_q       <= '0;
            cyc_q       <= 1'b0;
            abort_q     <= 1'b0;
            immu_ack_q  <= 1'b0;
            dmmu_ack_q  <= 1'b0;
            immu_data_q <= '0;
            dmmu_data_q <= '0;
        end else begin
            immu_ack_q <= 1'b0;
            dmmu_ack_q <= 1'b0;
            case (state_q)
                RLD_IDLE: begin
                    abort_q <= 1'b0;
                    if (|(grant & {dmmu_req_i, immu_req_i})) begin
                        gnt_q   <= grant;
                        adr_q   <= grant[1] ? dmmu_addr_i : immu_addr_i;
                        cyc_q   <= 1'b1;
                        state_q <= RLD_BUS;
                    end
                end
                RLD_BUS: begin
                    if (!gnt_req) begin
                        abort_q <= 1'b1;
                    end
                    if (bus_done) begin
                        cyc_q   <= 1'b0;
                        state_q <= RLD_RESP;
                        if (gnt_q[1]) begin
                            dmmu_data_q <= bus_word;
                        end else begin
                            immu_data_q <= bus_word;
                        end
                        // A requester that flushed mid-read must not see a stale ack.
                        if (!abort_q && gnt_req) begin
                            immu_ack_q <= gnt_q[0];
                            dmmu_ack_q <= gnt_q[1];
                        end
                    end
                end
                RLD_RESP: begin
                    state_q <= RLD_IDLE;
                end
                default: begin
                    state_q <= RLD_IDLE;
                    cyc_q   <= 1'b0;
                end
            endcase
        end
    end

    assign wbm_adr_o   = adr_q;
    assign wbm_cyc_o   = cyc_q;
    assign wbm_stb_o   = cyc_q;
    assign wbm_we_o    = 1'b0;
    assign wbm_sel_o   = 4'hf;
    assign wbm_cti_o   = WB_CTI_CLASSIC;
    assign wbm_bte_o   = WB_BTE_LINEAR;
    assign immu_ack_o  = immu_ack_q;
    assign dmmu_ack_o  = dmmu_ack_q;
    assign immu_data_o = immu_data_q;
    assign dmmu_data_o = dmmu_data_q;
    assign busy_o      = (state_q != RLD_IDLE);

endmodule

// File: tb/tb_mor1kx_tlb_reload_responder.sv
// tb/tb_mor1kx_tlb_reload_responder.sv - directed bench for the TLB reload responder
module tb_mor1kx_tlb_reload_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        immu_req_i = 1'b0;
    logic [31:0] immu_addr_i = '0;
    logic        immu_ack_o;
    logic [31:0] immu_data_o;
    logic        dmmu_req_i = 1'b0;
    logic [31:0] dmmu_addr_i = '0;
    logic        dmmu_ack_o;
    logic [31:0] dmmu_data_o;
    logic [31:0] wbm_adr_o;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [2:0]  wbm_cti_o;
    logic [1:0]  wbm_bte_o;
    logic [31:0] wbm_dat_i = '0;
    logic        wbm_ack_i = 1'b0;
    logic        wbm_err_i = 1'b0;
    logic        busy_o;

    int n_vec = 0;
    int n_err = 0;
    int immu_ack_cnt = 0;
    int dmmu_ack_cnt = 0;
    int both_ack_cnt = 0;

    always #5 clk = ~clk;

    mor1kx_tlb_reload_responder #(
        .OPTION_OPERAND_WIDTH  (32),
        .OPTION_RELOAD_TIMEOUT (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .immu_req_i  (immu_req_i),
        .immu_addr_i (immu_addr_i),
        .immu_ack_o  (immu_ack_o),
        .immu_data_o (immu_data_o),
        .dmmu_req_i  (dmmu_req_i),
        .dmmu_addr_i (dmmu_addr_i),
        .dmmu_ack_o  (dmmu_ack_o),
        .dmmu_data_o (dmmu_data_o),
        .wbm_adr_o   (wbm_adr_o),
        .wbm_cyc_o   (wbm_cyc_o),
        .wbm_stb_o   (wbm_stb_o),
        .wbm_we_o    (wbm_we_o),
        .wbm_sel_o   (wbm_sel_o),
        .wbm_cti_o   (wbm_cti_o),
        .wbm_bte_o   (wbm_bte_o),
        .wbm_dat_i   (wbm_dat_i),
        .wbm_ack_i   (wbm_ack_i),
        .wbm_err_i   (wbm_err_i),
        .busy_o      (busy_o)
    );

    always @(negedge clk) begin
        if (immu_ack_o) immu_ack_cnt++;
        if (dmmu_ack_o) dmmu_ack_cnt++;
        if (immu_ack_o && dmmu_ack_o) both_ack_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for a bus cycle, returns its address, then answers it.
    task automatic bus_reply(input int dly, input logic do_ack, input logic do_err,
                             input logic [31:0] dat, output logic [31:0] adr);
        int n = 0;
        while (!wbm_cyc_o && n < 20) begin
            step();
            n++;
        end
        n_vec++;
        if (!wbm_cyc_o) begin
            n_err++;
            $display("FAIL bus_start: cyc=%b required 1 within 20 cycles", wbm_cyc_o);
            adr = 32'hxxxx_xxxx;
            return;
        end
        adr = wbm_adr_o;
        repeat (dly) step();
        wbm_ack_i = do_ack;
        wbm_err_i = do_err;
        wbm_dat_i = dat;
        step();
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_vec++; if ({wbm_cyc_o, wbm_stb_o, busy_o, immu_ack_o, dmmu_ack_o} !== 5'b0) begin
            n_err++; $display("FAIL reset_ctrl: cyc/stb/busy/acks=%b required 00000",
                              {wbm_cyc_o, wbm_stb_o, busy_o, immu_ack_o, dmmu_ack_o}); end
        n_vec++; if ({wbm_adr_o, immu_data_o, dmmu_data_o} !== 96'h0) begin
            n_err++; $display("FAIL reset_data: adr=%h idata=%h ddata=%h required 0",
                              wbm_adr_o, immu_data_o, dmmu_data_o); end
        n_vec++; if ({wbm_we_o, wbm_sel_o, wbm_cti_o, wbm_bte_o} !== {1'b0, 4'hf, 3'b000, 2'b00}) begin
            n_err++; $display("FAIL reset_const: we/sel/cti/bte=%b required 0111100000",
                              {wbm_we_o, wbm_sel_o, wbm_cti_o, wbm_bte_o}); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_round_robin();
        logic [31:0] adr;
        immu_addr_i = 32'h0000_0100;
        dmmu_addr_i = 32'h0000_0200;
        immu_req_i = 1'b1;
        dmmu_req_i = 1'b1;
        bus_reply(0, 1'b1, 1'b0, 32'h1111_1000, adr);
        n_vec++; if (adr !== 32'h0000_0100) begin
            n_err++; $display("FAIL rr_first: adr=%h required 00000100", adr); end
        n_vec++; if ({immu_ack_o, dmmu_ack_o} !== 2'b10) begin
            n_err++; $display("FAIL rr_first_ack: i/d ack=%b required 10", {immu_ack_o, dmmu_ack_o}); end
        immu_req_i = 1'b0;
        dmmu_req_i = 1'b0;
        step();
        immu_req_i = 1'b1;
        dmmu_req_i = 1'b1;
        bus_reply(0, 1'b1, 1'b0, 32'h2222_2000, adr);
        n_vec++; if (adr !== 32'h0000_0200) begin
            n_err++; $display("FAIL rr_second: adr=%h required 00000200", adr); end
        n_vec++; if ({immu_ack_o, dmmu_ack_o, dmmu_data_o} !== {2'b01, 32'h2222_2000}) begin
            n_err++; $display("FAIL rr_second_ack: i/d ack=%b ddata=%h required 01 22222000",
                              {immu_ack_o, dmmu_ack_o}, dmmu_data_o); end
        dmmu_req_i = 1'b0;
        step();
        bus_reply(0, 1'b1, 1'b0, 32'h3333_3000, adr);
        n_vec++; if (adr !== 32'h0000_0100 || immu_ack_o !== 1'b1) begin
            n_err++; $display("FAIL rr_third: adr=%h iack=%b required 00000100 1", adr, immu_ack_o); end
        immu_req_i = 1'b0;
        step();
    endtask

    task automatic test_single_read();
        logic [31:0] adr;
        int d0;
        d0 = dmmu_ack_cnt;
        immu_addr_i = 32'h0000_1004;
        immu_req_i = 1'b1;
        bus_reply(2, 1'b1, 1'b0, 32'hABCD_E400, adr);
        n_vec++; if (adr !== 32'h0000_1004) begin
            n_err++; $display("FAIL single_adr: adr=%h required 00001004", adr); end
        n_vec++; if (immu_ack_o !== 1'b1 || immu_data_o !== 32'hABCD_E400) begin
            n_err++; $display("FAIL single_ack: iack=%b idata=%h required 1 abcde400",
                              immu_ack_o, immu_data_o); end
        n_vec++; if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0) begin
            n_err++; $display("FAIL single_cyc_drop: cyc=%b stb=%b required 0 0", wbm_cyc_o, wbm_stb_o); end
        immu_req_i = 1'b0;
        step();
        n_vec++; if (immu_ack_o !== 1'b0 || immu_data_o !== 32'hABCD_E400) begin
            n_err++; $display("FAIL single_pulse: iack=%b idata=%h required 0 abcde400",
                              immu_ack_o, immu_data_o); end
        n_vec++; if (dmmu_ack_cnt !== d0) begin
            n_err++; $display("FAIL single_dmmu_quiet: dmmu acks=%0d required %0d", dmmu_ack_cnt, d0); end
    endtask

    task automatic test_walk();
        logic [31:0] adr;
        int d0;
        d0 = dmmu_ack_cnt;
        immu_addr_i = 32'h0000_2008;
        immu_req_i = 1'b1;
        step();
        dmmu_addr_i = 32'h0000_3000;
        dmmu_req_i = 1'b1;
        bus_reply(1, 1'b1, 1'b0, 32'h0040_0000, adr);
        n_vec++; if (adr !== 32'h0000_2008 || immu_data_o !== 32'h0040_0000 || immu_ack_o !== 1'b1) begin
            n_err++; $display("FAIL walk_l1: adr=%h idata=%h iack=%b required 00002008 00400000 1",
                              adr, immu_data_o, immu_ack_o); end
        immu_addr_i = 32'h0040_0010;
        bus_reply(1, 1'b1, 1'b0, 32'hDEAD_B000, adr);
        n_vec++; if (adr !== 32'h0040_0010 || immu_data_o !== 32'hDEAD_B000) begin
            n_err++; $display("FAIL walk_l2: adr=%h idata=%h required 00400010 deadb000", adr, immu_data_o); end
        n_vec++; if (dmmu_ack_cnt !== d0) begin
            n_err++; $display("FAIL walk_dmmu_held: dmmu acks=%0d required %0d", dmmu_ack_cnt, d0); end
        immu_req_i = 1'b0;
        bus_reply(0, 1'b1, 1'b0, 32'hCAFE_0000, adr);
        n_vec++; if (adr !== 32'h0000_3000 || dmmu_ack_o !== 1'b1 || dmmu_data_o !== 32'hCAFE_0000) begin
            n_err++; $display("FAIL walk_dmmu: adr=%h dack=%b ddata=%h required 00003000 1 cafe0000",
                              adr, dmmu_ack_o, dmmu_data_o); end
        dmmu_req_i = 1'b0;
        step();
    endtask

    task automatic test_bus_error();
        logic [31:0] adr;
        dmmu_addr_i = 32'h0000_5000;
        dmmu_req_i = 1'b1;
        bus_reply(1, 1'b0, 1'b1, 32'h1234_5678, adr);
        n_vec++; if (dmmu_ack_o !== 1'b1 || dmmu_data_o !== 32'h0 || wbm_cyc_o !== 1'b0) begin
            n_err++; $display("FAIL err_resp: dack=%b ddata=%h cyc=%b required 1 00000000 0",
                              dmmu_ack_o, dmmu_data_o, wbm_cyc_o); end
        dmmu_req_i = 1'b0;
        step();
        dmmu_addr_i = 32'h0000_5008;
        dmmu_req_i = 1'b1;
        bus_reply(0, 1'b1, 1'b0, 32'h0BAD_F000, adr);
        n_vec++; if (dmmu_data_o !== 32'h0BAD_F000 || adr !== 32'h0000_5008) begin
            n_err++; $display("FAIL err_recover: adr=%h ddata=%h required 00005008 0badf000", adr, dmmu_data_o); end
        dmmu_req_i = 1'b0;
        step();
        dmmu_req_i = 1'b1;
        bus_reply(0, 1'b1, 1'b1, 32'hFFFF_FFFF, adr);
        n_vec++; if (dmmu_ack_o !== 1'b1 || dmmu_data_o !== 32'h0) begin
            n_err++; $display("FAIL err_wins: dack=%b ddata=%h required 1 00000000", dmmu_ack_o, dmmu_data_o); end
        dmmu_req_i = 1'b0;
        step();
    endtask

    task automatic test_timeout();
        int n = 0;
        int hi = 0;
        immu_addr_i = 32'h0000_6000;
        immu_req_i = 1'b1;
        while (!wbm_cyc_o && n < 20) begin step(); n++; end
        while (wbm_cyc_o && hi < 30) begin step(); hi++; end
        n_vec++; if (hi !== 8) begin
            n_err++; $display("FAIL timeout_len: cyc high %0d cycles required 8", hi); end
        n_vec++; if (immu_ack_o !== 1'b1 || immu_data_o !== 32'h0 || wbm_stb_o !== 1'b0) begin
            n_err++; $display("FAIL timeout_resp: iack=%b idata=%h stb=%b required 1 00000000 0",
                              immu_ack_o, immu_data_o, wbm_stb_o); end
        immu_req_i = 1'b0;
        step();
    endtask

    task automatic test_flush();
        logic [31:0] adr;
        int i0;
        i0 = immu_ack_cnt;
        immu_addr_i = 32'h0000_7000;
        immu_req_i = 1'b1;
        step();
        immu_req_i = 1'b0;
        bus_reply(1, 1'b1, 1'b0, 32'h7777_7000, adr);
        n_vec++; if (wbm_cyc_o !== 1'b0 || immu_ack_o !== 1'b0) begin
            n_err++; $display("FAIL flush_resp: cyc=%b iack=%b required 0 0", wbm_cyc_o, immu_ack_o); end
        step();
        step();
        n_vec++; if (immu_ack_cnt !== i0 || busy_o !== 1'b0) begin
            n_err++; $display("FAIL flush_noack: iacks=%0d busy=%b required %0d 0", immu_ack_cnt, busy_o, i0); end
    endtask

    task automatic test_async_reset();
        int i0;
        i0 = immu_ack_cnt;
        immu_addr_i = 32'h0000_8000;
        immu_req_i = 1'b1;
        step();
        n_vec++; if (wbm_cyc_o !== 1'b1) begin
            n_err++; $display("FAIL areset_pre: cyc=%b required 1", wbm_cyc_o); end
        #2 rst = 1'b1;
        #1;
        n_vec++; if ({wbm_cyc_o, wbm_stb_o, busy_o, wbm_adr_o} !== 35'h0) begin
            n_err++; $display("FAIL areset_drop: cyc=%b stb=%b busy=%b adr=%h required 0 0 0 0",
                              wbm_cyc_o, wbm_stb_o, busy_o, wbm_adr_o); end
        immu_req_i = 1'b0;
        step();
        rst = 1'b0;
        wbm_ack_i = 1'b1;
        step();
        wbm_ack_i = 1'b0;
        repeat (3) step();
        n_vec++; if (immu_ack_cnt !== i0 || wbm_cyc_o !== 1'b0) begin
            n_err++; $display("FAIL areset_noack: iacks=%0d cyc=%b required %0d 0", immu_ack_cnt, wbm_cyc_o, i0); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_read();
        test_walk();
        test_bus_error();
        test_timeout();
        test_flush();
        test_async_reset();
        n_vec++; if (both_ack_cnt !== 0) begin
            n_err++; $display("FAIL ack_exclusive: both-high cycles=%0d required 0", both_ack_cnt); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mor1kx_tlb_reload_responder.md
Name: mor1kx_tlb_reload_responder

Overview:
- Services hardware TLB-reload read requests from the instruction MMU and data MMU.
- Each MMU holds its request high and presents a PTE-pointer or PTE word address. This block arbitrates between the two MMUs, performs a single-word Wishbone classic read, and returns the word with a one-cycle ack pulse.
- Sits between the MMUs' tlb_reload_* ports and a dedicated Wishbone master port, which the bus arbiter merges with the fetch and LSU masters.

Parameters:
- OPTION_OPERAND_WIDTH, 32: address and data width.
- OPTION_RELOAD_TIMEOUT, 0: cycles to wait for wbm_ack_i/wbm_err_i before forcing an error; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- immu_req_i  in  1  IMMU reload request; held high across the pointer and PTE reads
- immu_addr_i  in  32  IMMU word address; bits [1:0] are 0
- immu_ack_o  out  1  one-cycle pulse; immu_data_o is valid in this cycle
- immu_data_o  out  32  read data returned to the IMMU
- dmmu_req_i  in  1  DMMU reload request
- dmmu_addr_i  in  32  DMMU word address
- dmmu_ack_o  out  1  one-cycle pulse to the DMMU
- dmmu_data_o  out  32  read data returned to the DMMU
- wbm_adr_o  out  32  bus address
- wbm_cyc_o  out  1  bus cycle
- wbm_stb_o  out  1  bus strobe
- wbm_we_o  out  1  constant 0
- wbm_sel_o  out  4  constant 4'hf
- wbm_cti_o  out  3  constant 3'b000
- wbm_bte_o  out  2  constant 2'b00
- wbm_dat_i  in  32  bus read data
- wbm_ack_i  in  1  bus acknowledge
- wbm_err_i  in  1  bus error
- busy_o  out  1  high in any state other than IDLE

Behaviour:
- Reset values: wbm_cyc_o=0, wbm_stb_o=0, wbm_adr_o=0, both acks 0, both data outputs 0, grant=IMMU, last-winner=DMMU, state=IDLE.
- FSM states:
  - IDLE → BUS: when the granted requester has req=1. Latch its address into wbm_adr_o and assert cyc/stb on the next edge.
  - BUS → RESP: on wbm_ack_i, capture wbm_dat_i; drop cyc/stb on the same edge.
  - BUS → RESP on error: on wbm_err_i or timeout, capture 32'h0. A zero word makes the requester take its own pagefault path (PPN==0 or PRESENT==0). No separate error signal.
  - RESP → IDLE: pulse the granted requester's ack_o for exactly one cycle; data is held until the next capture.
- Latency: req seen in IDLE at cycle N; cyc/stb high at N+1; bus ack at cycle M ≥ N+1; ack_o at M+1. Minimum 3 cycles from req to ack.
- A fresh request is not sampled in RESP. The requester updates its address on the ack edge, so the next IDLE cycle sees the new address.
- Arbitration:
  - Evaluated only in IDLE.
  - Grant is sticky while the current owner holds req high, so a two-level walk is never interleaved.
  - When the owner's req is low in IDLE, grant moves round-robin: the requester that did not win last gets priority.
  - Simultaneous first requests after reset: IMMU wins.
- Requester drops req while in BUS (flush): the bus cycle completes normally, ack_o is suppressed, and the FSM returns to IDLE (abort flag set in BUS, cleared in IDLE).
- Timeout:
  - A counter clears on entering BUS and increments each BUS cycle.
  - When count == OPTION_RELOAD_TIMEOUT-1 with no ack/err, treat as error and drop cyc/stb.
  - When OPTION_RELOAD_TIMEOUT=0, the counter is not generated.
- Same-cycle wbm_ack_i and wbm_err_i: err wins and data is 0.
- Asynchronous rst mid-transaction: cyc/stb drop immediately and no ack is issued.
- Non-owner acks never assert; the two ack outputs are never high together.

Decomposition:
- Shared constants go in the core defines file: state encodings RLD_IDLE=2'd0, RLD_BUS=2'd1, RLD_RESP=2'd2, and the Wishbone CTI/BTE classic constants.
- One natural sub-module: mor1kx_tlb_reload_arb, a 2-way sticky round-robin grant taking req[1:0], an idle strobe, and clk/rst, and producing a one-hot grant.

Test Plan:
- Single read: IMMU req with addr 32'h0000_1004, bus acks 2 cycles after stb with data 32'hABCD_E400 → wbm_adr_o=32'h0000_1004; immu_ack_o pulses one cycle with immu_data_o=32'hABCD_E400; dmmu_ack_o stays 0.
- Two-level walk: IMMU holds req; first ack returns 32'h0040_0000, then addr changes to 32'h0040_0010 → second bus read at 32'h0040_0010; DMMU req asserted throughout is not granted until IMMU drops req.
- Round-robin: IMMU and DMMU request together from reset → IMMU served first; after both reissue, DMMU is served first.
- Bus error: wbm_err_i on the DMMU read → dmmu_ack_o pulses with dmmu_data_o=32'h0; cyc drops the same edge.
- Timeout with OPTION_RELOAD_TIMEOUT=8 and no ack → cyc/stb drop after 8 BUS cycles; ack_o pulses with data 0.
- Flush and reset: IMMU req drops mid-BUS → bus completes, no immu_ack_o. rst asserted mid-BUS → cyc/stb=0 the same cycle, state=IDLE, no ack afterwards.
